// File: rtl/noc_fifo_pkg.sv
// Shared definitions for the NoC router input-stage byte FIFOs: default
// geometry and the packet-type codes carried in bits [2:0] of a header byte.
package noc_fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 32;

  localparam logic [2:0] READ_RESP  = 3'b011;
  localparam logic [2:0] WRITE_RESP = 3'b100;
  localparam logic [2:0] MESSAGE    = 3'b101;

  function automatic logic [2:0] pkt_type(input logic [FIFO_WIDTH-1:0] head);
    return head[2:0];
  endfunction

endpackage

// File: rtl/single_fifo_mem.sv
// Register-array storage for single_fifo_core: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module single_fifo_mem
  import noc_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/single_fifo_core.sv
// First-word-fall-through byte FIFO with wrap-bit pointers. Defining
// SINGLE_FIFO_ERR_EN adds sticky overflow/underflow outputs.
module single_fifo_core
  import noc_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             write,
  input  logic             read,
  output logic [WIDTH-1:0] out,
  output logic             empty,
  output logic             full
`ifdef SINGLE_FIFO_ERR_EN
  ,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_chk
    $error("single_fifo_core: DEPTH must be a power of two >= 2");
  end

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_rdata;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                 (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // A pop frees the slot in the same edge, so a full FIFO still accepts a push alongside it.
  assign w_pop  = read && !empty;
  assign w_push = write && (!full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  single_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (in),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  assign out = empty ? '0 : w_rdata;

`ifdef SINGLE_FIFO_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (write && full && !read) r_overflow  <= 1'b1;
      if (read && empty)          r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`endif

endmodule

// File: tb/tb_single_fifo_core.sv
// Self-checking bench for single_fifo_core: vector table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_single_fifo_core;

  localparam int W = 8;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in;
  logic         write;
  logic         read;
  logic [W-1:0] out;
  logic         empty;
  logic         full;
`ifdef SINGLE_FIFO_ERR_EN
  logic         overflow;
  logic         underflow;
  bit           m_ovf;
  bit           m_unf;
`endif

  always #5 clk = ~clk;

  single_fifo_core #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (in),
    .write (write),
    .read  (read),
    .out   (out),
    .empty (empty),
    .full  (full)
`ifdef SINGLE_FIFO_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] mdl[$];

  typedef struct {
    bit           w;
    bit           r;
    logic [W-1:0] d;
    logic [W-1:0] eo;
    bit           ee;
    bit           ef;
  } vec_t;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    cmp({tag, " empty"}, empty, mdl.size() == 0);
    cmp({tag, " full"},  full,  mdl.size() == D);
    cmp({tag, " out"},   out,   (mdl.size() == 0) ? 8'h00 : mdl[0]);
`ifdef SINGLE_FIFO_ERR_EN
    cmp({tag, " overflow"},  overflow,  m_ovf);
    cmp({tag, " underflow"}, underflow, m_unf);
`endif
  endtask

  // Drive one cycle, let the model follow the FIFO rules, sample 1ns after the edge.
  task automatic step(input bit w, input bit r, input logic [W-1:0] d);
    bit pop;
    bit push;
    write = w;
    read  = r;
    in    = d;
    @(posedge clk);
    pop  = r && (mdl.size() > 0);
    push = w && ((mdl.size() < D) || pop);
`ifdef SINGLE_FIFO_ERR_EN
    if (w && (mdl.size() == D) && !r) m_ovf = 1'b1;
    if (r && (mdl.size() == 0))       m_unf = 1'b1;
`endif
    if (pop)  void'(mdl.pop_front());
    if (push) mdl.push_back(d);
    #1;
    write = 1'b0;
    read  = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 0, 8'h23, 8'h23, 0, 0};
    tbl[1]  = '{0, 1, 8'h00, 8'h00, 1, 0};
    tbl[2]  = '{0, 1, 8'h00, 8'h00, 1, 0};
    tbl[3]  = '{1, 0, 8'h03, 8'h03, 0, 0};
    tbl[4]  = '{1, 0, 8'h11, 8'h03, 0, 0};
    tbl[5]  = '{1, 0, 8'h22, 8'h03, 0, 0};
    tbl[6]  = '{0, 1, 8'h00, 8'h11, 0, 0};
    tbl[7]  = '{0, 1, 8'h00, 8'h22, 0, 0};
    tbl[8]  = '{0, 1, 8'h00, 8'h00, 1, 0};
    tbl[9]  = '{1, 1, 8'h5A, 8'h5A, 0, 0};
    tbl[10] = '{1, 1, 8'h6B, 8'h6B, 0, 0};
    tbl[11] = '{0, 1, 8'h00, 8'h00, 1, 0};

    write = 1'b0;
    read  = 1'b0;
    in    = '0;
    reset = 1'b0;
`ifdef SINGLE_FIFO_ERR_EN
    m_ovf = 1'b0;
    m_unf = 1'b0;
`endif
    #12;
    cmp("reset empty", empty, 1'b1);
    cmp("reset full",  full,  1'b0);
    cmp("reset out",   out,   8'h00);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_model("idle");

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].w, tbl[i].r, tbl[i].d);
      cmp($sformatf("vec%0d empty", i), empty, tbl[i].ee);
      cmp($sformatf("vec%0d full", i),  full,  tbl[i].ef);
      cmp($sformatf("vec%0d out", i),   out,   tbl[i].eo);
    end
`ifdef SINGLE_FIFO_ERR_EN
    cmp("underflow after empty read", underflow, 1'b1);
`endif

    // Fill to DEPTH, overflow attempt, then simultaneous push/pop while full.
    for (int i = 0; i < D; i++) begin
      step(1, 0, W'(i));
      cmp($sformatf("fill%0d full", i), full, (i == D - 1));
    end
    cmp("full head", out, 8'h00);
    step(1, 0, 8'hAA);
    cmp("overflow keeps full", full, 1'b1);
    cmp("overflow keeps head", out, 8'h00);
`ifdef SINGLE_FIFO_ERR_EN
    cmp("overflow flag", overflow, 1'b1);
`endif
    step(1, 1, 8'h55);
    cmp("full rw full", full, 1'b1);
    cmp("full rw out",  out,  8'h01);
    for (int i = 1; i <= D; i++) begin
      cmp($sformatf("drain%0d out", i), out, (i == D) ? 8'h55 : W'(i));
      step(0, 1, 8'h00);
      if (i == 1) cmp("full falls after pop", full, 1'b0);
    end
    cmp("drained empty", empty, 1'b1);
    cmp("drained out",   out,   8'h00);

    // Interleaved write/read pairs to wrap the pointers several times.
    for (int i = 0; i < 40; i++) begin
      step(1, 0, W'($urandom));
      check_model($sformatf("pairw%0d", i));
      step(0, 1, 8'h00);
      check_model($sformatf("pairr%0d", i));
    end

    // Randomized traffic: fill-biased phase then drain-biased phase.
    for (int i = 0; i < 400; i++) begin
      bit w;
      bit r;
      if (i < 200) begin
        w = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        w = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      step(w, r, W'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 5; i++) step(1, 0, W'(8'h70 + i));
    check_model("pre-reset");
    #2;
    reset = 1'b0;
    #1;
    cmp("async reset empty", empty, 1'b1);
    cmp("async reset full",  full,  1'b0);
    cmp("async reset out",   out,   8'h00);
    mdl.delete();
`ifdef SINGLE_FIFO_ERR_EN
    m_ovf = 1'b0;
    m_unf = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_model("post-reset");
    step(1, 0, 8'h3C);
    check_model("post-reset write");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
